// File: rtl/mem_copy_engine.sv
// Word-by-word RAM-to-RAM copy engine: READ -> WAIT(READ_LATENCY) -> WRITE per word.
// All RAM-facing outputs and status flags are registered from next-state values.
module mem_copy_engine #(
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] ADDR_STEP    = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic [15:0] word_count,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    output logic        ram_read_enable,
    output logic        ram_write_enable,
    input  logic [31:0] ram_data_out
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_READ  | read strobe to src_ptr
    // S_WAIT  | READ_LATENCY cycles, capture read data on the last one
    // S_WRITE | write strobe of hold_reg to dst_ptr
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] src_ptr_q, src_ptr_d;
    logic [31:0] dst_ptr_q, dst_ptr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            len_q     <= '0;
            count_q   <= '0;
            wait_q    <= '0;
            hold_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            len_q     <= len_d;
            count_q   <= count_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        len_d     = len_q;
        count_d   = count_q;
        wait_d    = wait_q;
        hold_d    = hold_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (length != 16'd0) begin
                        src_ptr_d = src_addr;
                        dst_ptr_d = dst_addr;
                        len_d     = length;
                        state_d   = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                wait_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 3'd0) begin
                    hold_d  = ram_data_out;
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_WRITE: begin
                // pointers wrap silently at 2^32
                src_ptr_d = src_ptr_q + ADDR_STEP;
                dst_ptr_d = dst_ptr_q + ADDR_STEP;
                count_d   = count_q + 16'd1;
                state_d   = (count_d == len_q) ? S_DONE : S_READ;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        rd_en_d = (state_d == S_READ);
        wr_en_d = (state_d == S_WRITE);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (rd_en_d) begin
            addr_d = src_ptr_d;
        end else if (wr_en_d) begin
            addr_d  = dst_ptr_d;
            wdata_d = hold_d;
        end
        busy_d = rd_en_d | wr_en_d | (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign word_count       = count_q;
    assign ram_addr         = addr_q;
    assign ram_data_in      = wdata_q;
    assign ram_read_enable  = rd_en_q;
    assign ram_write_enable = wr_en_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine: one instance at READ_LATENCY=1, one at READ_LATENCY=3,
// each with a small behavioural RAM whose read data is valid for exactly one cycle.
module tb_mem_copy_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [15:0] len = '0;

    logic        busy_a, done_a, re_a, we_a;
    logic [15:0] wc_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        busy_b, done_b, re_b, we_b;
    logic [15:0] wc_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    mem_copy_engine #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .src_addr(src), .dst_addr(dst), .length(len),
        .busy(busy_a), .done(done_a), .word_count(wc_a),
        .ram_addr(addr_a), .ram_data_in(wdata_a),
        .ram_read_enable(re_a), .ram_write_enable(we_a),
        .ram_data_out(rdata_a)
    );

    mem_copy_engine #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .src_addr(src), .dst_addr(dst), .length(len),
        .busy(busy_b), .done(done_b), .word_count(wc_b),
        .ram_addr(addr_b), .ram_data_in(wdata_b),
        .ram_read_enable(re_b), .ram_write_enable(we_b),
        .ram_data_out(rdata_b)
    );

    // RAM models; preload goes through the same port process to keep one writer per array
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [16];
    logic [31:0] pipe_b [3];
    logic        pl_a = 1'b0, pl_b = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_a) mem_a[pl_addr] <= pl_data;
        else if (we_a) mem_a[addr_a[7:0]] <= wdata_a;
        rdata_a <= re_a ? mem_a[addr_a[7:0]] : 32'hDEADBEEF;
    end

    always @(posedge clk) begin
        if (pl_b) mem_b[pl_addr[3:0]] <= pl_data;
        else if (we_b) mem_b[addr_b[3:0]] <= wdata_b;
        pipe_b[0] <= re_b ? mem_b[addr_b[3:0]] : 32'hDEADBEEF;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rdata_b = pipe_b[2];

    int          cyc = 0;
    int          ovl_a = 0, ovl_b = 0, done_cnt_a = 0;
    bit          busy_seen_a = 1'b0;
    logic [31:0] rd_q_a[$], wr_q_a[$];
    int          rd_cyc_b[$], wr_cyc_b[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (re_a && we_a) ovl_a++;
        if (re_a) rd_q_a.push_back(addr_a);
        if (we_a) wr_q_a.push_back(addr_a);
        if (busy_a) busy_seen_a = 1'b1;
        if (done_a) done_cnt_a++;
        if (re_b && we_b) ovl_b++;
        if (re_b) rd_cyc_b.push_back(cyc);
        if (we_b) wr_cyc_b.push_back(cyc);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic preload_a(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a; pl_data = d; pl_a = 1'b1;
        @(negedge clk);
        pl_a = 1'b0;
    endtask

    task automatic preload_b(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a; pl_data = d; pl_b = 1'b1;
        @(negedge clk);
        pl_b = 1'b0;
    endtask

    task automatic clear_logs();
        rd_q_a.delete(); wr_q_a.delete();
        busy_seen_a = 1'b0; done_cnt_a = 0;
    endtask

    task automatic start_copy_a(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        src = s; dst = d; len = l; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    // counts negedges after the accepting edge until done is seen
    task automatic wait_done_a(input string tag, input int exp);
        int n;
        for (n = 1; n <= 1000; n++) begin
            @(negedge clk);
            if (done_a) break;
        end
        check(tag, n, exp);
        @(negedge clk);
        check({tag, "_pulse_width"}, done_a, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with start held high: reset must win
        start_a = 1'b1; src = 32'd0; dst = 32'd0; len = 16'd5;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_re", re_a, 1'b0);
        check("rst_we", we_a, 1'b0);
        check("rst_addr", addr_a, 32'h0);
        check("rst_wdata", wdata_a, 32'h0);
        check("rst_wc", wc_a, 32'h0);
        reset = 1'b0; start_a = 1'b0;
        @(negedge clk);
        check("rst_no_accept", busy_a, 1'b0);

        // basic 10-word copy
        for (int i = 0; i < 10; i++) preload_a(8'(i), 32'hA5A5A5A5 + 32'(i));
        for (int i = 16; i < 26; i++) preload_a(8'(i), 32'h0);
        clear_logs();
        start_copy_a(32'd0, 32'd16, 16'd10);
        wait_done_a("basic_done_lat", 31);
        for (int i = 0; i < 10; i++) check($sformatf("basic_mem%0d", 16 + i), mem_a[16 + i], 32'hA5A5A5A5 + 32'(i));
        check("basic_wc", wc_a, 32'd10);
        check("basic_nwr", wr_q_a.size(), 32'd10);
        check("basic_nrd", rd_q_a.size(), 32'd10);

        // zero length
        clear_logs();
        start_copy_a(32'd0, 32'd200, 16'd0);
        wait_done_a("zero_done_lat", 1);
        check("zero_nrd", rd_q_a.size(), 32'd0);
        check("zero_nwr", wr_q_a.size(), 32'd0);
        check("zero_busy", busy_seen_a, 1'b0);

        // source pointer wraps past 2^32
        preload_a(8'hFE, 32'h11111111);
        preload_a(8'hFF, 32'h22222222);
        preload_a(8'h00, 32'h33333333);
        preload_a(8'h01, 32'h44444444);
        clear_logs();
        start_copy_a(32'hFFFFFFFE, 32'd100, 16'd4);
        wait_done_a("wrap_done_lat", 13);
        begin
            logic [31:0] exp_rd [4];
            logic [31:0] exp_d  [4];
            exp_rd = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
            exp_d  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
            check("wrap_nrd", rd_q_a.size(), 32'd4);
            check("wrap_nwr", wr_q_a.size(), 32'd4);
            if (rd_q_a.size() == 4 && wr_q_a.size() == 4) begin
                for (int i = 0; i < 4; i++) begin
                    check($sformatf("wrap_rd%0d", i), rd_q_a[i], exp_rd[i]);
                    check($sformatf("wrap_wr%0d", i), wr_q_a[i], 32'd100 + 32'(i));
                    check($sformatf("wrap_mem%0d", i), mem_a[100 + i], exp_d[i]);
                end
            end
        end

        // reset after the third write aborts the copy
        for (int i = 0; i < 10; i++) preload_a(8'(i), 32'hA5A5A5A5 + 32'(i));
        for (int i = 40; i < 50; i++) preload_a(8'(i), 32'h0);
        clear_logs();
        start_copy_a(32'd0, 32'd40, 16'd10);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (wr_q_a.size() == 3) break;
        end
        check("abort_reached_w3", wr_q_a.size(), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("abort_re", re_a, 1'b0);
        check("abort_we", we_a, 1'b0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_addr", addr_a, 32'h0);
        check("abort_wc", wc_a, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("abort_nwr", wr_q_a.size(), 32'd3);
        check("abort_nrd", rd_q_a.size(), 32'd3);
        check("abort_no_done", done_cnt_a, 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("abort_mem%0d", 40 + i), mem_a[40 + i], 32'hA5A5A5A5 + 32'(i));
        check("abort_mem43", mem_a[43], 32'h0);
        clear_logs();
        start_copy_a(32'd0, 32'd40, 16'd10);
        wait_done_a("restart_done_lat", 31);
        check("restart_mem49", mem_a[49], 32'hA5A5A5AE);
        check("restart_wc", wc_a, 32'd10);

        // start with new arguments while busy is ignored
        for (int i = 60; i < 65; i++) preload_a(8'(i), 32'h0);
        preload_a(8'd120, 32'h0);
        preload_a(8'd121, 32'h0);
        clear_logs();
        start_copy_a(32'd0, 32'd60, 16'd5);
        begin
            int n;
            for (n = 1; n <= 200; n++) begin
                @(negedge clk);
                if (n == 4) begin
                    src = 32'd3; dst = 32'd120; len = 16'd2; start_a = 1'b1;
                end
                if (n == 5) start_a = 1'b0;
                if (done_a) break;
            end
            check("busy_start_done_lat", n, 32'd16);
        end
        repeat (10) @(negedge clk);
        #1;
        check("busy_start_nwr", wr_q_a.size(), 32'd5);
        if (wr_q_a.size() == 5) begin
            check("busy_start_wr0", wr_q_a[0], 32'd60);
            check("busy_start_wr4", wr_q_a[4], 32'd64);
        end
        check("busy_start_mem64", mem_a[64], 32'hA5A5A5A9);
        check("busy_start_mem120", mem_a[120], 32'h0);
        check("busy_start_wc", wc_a, 32'd5);
        check("busy_start_idle", busy_a, 1'b0);

        // READ_LATENCY = 3 instance
        preload_b(8'd0, 32'hCAFE0000);
        preload_b(8'd1, 32'hCAFE0001);
        preload_b(8'd8, 32'h0);
        preload_b(8'd9, 32'h0);
        rd_cyc_b.delete(); wr_cyc_b.delete();
        @(negedge clk);
        src = 32'd0; dst = 32'd8; len = 16'd2; start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        begin
            int n;
            for (n = 1; n <= 200; n++) begin
                @(negedge clk);
                if (done_b) break;
            end
            check("lat3_done_lat", n, 32'd11);
        end
        #1;
        check("lat3_nrd", rd_cyc_b.size(), 32'd2);
        check("lat3_nwr", wr_cyc_b.size(), 32'd2);
        if (rd_cyc_b.size() == 2 && wr_cyc_b.size() == 2) begin
            check("lat3_gap0", wr_cyc_b[0] - rd_cyc_b[0], 32'd4);
            check("lat3_gap1", wr_cyc_b[1] - rd_cyc_b[1], 32'd4);
        end
        check("lat3_mem8", mem_b[8], 32'hCAFE0000);
        check("lat3_mem9", mem_b[9], 32'hCAFE0001);
        check("lat3_wc", wc_b, 32'd2);

        check("overlap_a", ovl_a, 32'd0);
        check("overlap_b", ovl_b, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 1: cycles from the edge sampling ram_read_enable to valid ram_data_out; legal range 1..4.
REQ-002 SHALL have parameter ADDR_STEP, default 1: address increment per word.
REQ-003 SHALL use one clock and a synchronous, active-high reset on the ports below.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  copy request, sampled only in IDLE.
REQ-007 src_addr  input  32  first source word address.
REQ-008 dst_addr  input  32  first destination word address.
REQ-009 length  input  16  number of words to copy.
REQ-010 busy  output  1  high in READ, WAIT and WRITE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 word_count  output  16  words written so far in the current copy.
REQ-013 ram_addr  output  32  RAM address, connects to RAM addr.
REQ-014 ram_data_in  output  32  write data, connects to RAM data_in.
REQ-015 ram_read_enable  output  1  connects to RAM read_enable.
REQ-016 ram_write_enable  output  1  connects to RAM write_enable.
REQ-017 ram_data_out  input  32  read data, driven from RAM data_out.

Function
REQ-018 SHALL implement states IDLE, READ, WAIT, WRITE and DONE.
REQ-019 IDLE, start=1 and length!=0: SHALL latch src_addr, dst_addr and length into src_ptr, dst_ptr and len_reg, clear word_count, and go to READ.
REQ-020 IDLE, start=1 and length=0: SHALL go to DONE with no RAM access.
REQ-021 READ, one cycle: SHALL drive ram_read_enable=1 and ram_addr=src_ptr, then go to WAIT.
REQ-022 WAIT, READ_LATENCY cycles: SHALL hold both enables low and capture ram_data_out into hold_reg on the last WAIT cycle, then go to WRITE.
REQ-023 WRITE, one cycle: SHALL drive ram_write_enable=1, ram_addr=dst_ptr and ram_data_in=hold_reg.
REQ-024 At the end of WRITE: src_ptr += ADDR_STEP, dst_ptr += ADDR_STEP, word_count += 1; next state DONE if the new word_count equals len_reg, else READ.
REQ-025 DONE, one cycle: SHALL assert done=1 and busy=0, then go to IDLE.
REQ-026 Address arithmetic SHALL wrap modulo 2^32 with no error indication.
REQ-027 ram_read_enable and ram_write_enable SHALL never be high in the same cycle.
REQ-028 Outside READ and WRITE, ram_addr and ram_data_in SHALL hold their last values and both enables SHALL be 0.
REQ-029 start SHALL be ignored outside IDLE, with no queuing.
REQ-030 src_addr, dst_addr and length changes after acceptance SHALL have no effect on the current copy.
REQ-031 Overlapping ranges SHALL copy in ascending address order with no hazard handling; a word at dst may be overwritten before it is read as src.
REQ-032 Per word: SHALL take exactly 2+READ_LATENCY cycles; done SHALL rise (2+READ_LATENCY)*length+1 cycles after the edge that accepts start.
REQ-033 length=65535 SHALL complete normally; word_count SHALL not overflow.

Reset
REQ-034 On reset=1 at a rising edge: state=IDLE, busy=0, done=0, ram_read_enable=0, ram_write_enable=0, ram_addr=0, ram_data_in=0, word_count=0, pointers and hold_reg=0.
REQ-035 Reset mid-copy SHALL abort at that edge with no further RAM access; words already written stay in RAM and done is not pulsed.
REQ-036 reset SHALL take priority over start in the same cycle.

Verification
REQ-037 Preload RAM[0..9]=32'hA5A5A5A5+i; start with src=0, dst=16, length=10 -> RAM[16..25]=A5A5A5A5..A5A5A5AE; done rises 31 cycles after acceptance; word_count=10.
REQ-038 start with length=0 -> done pulses in the cycle after acceptance; no enable ever high; busy stays 0.
REQ-039 src=32'hFFFFFFFE, dst=100, length=4 -> reads from FFFFFFFE, FFFFFFFF, 0, 1; writes to 100..103 in order.
REQ-040 Assert reset after the 3rd write of a 10-word copy -> enables low from that edge; only dst[0..2] written; no done pulse; a fresh start works normally.
REQ-041 Pulse start while busy with different arguments -> ignored; original copy completes unchanged.
REQ-042 Run with READ_LATENCY=3 and length=2, src=0, dst=8 -> read-to-write spacing is 4 cycles; done rises 11 cycles after acceptance; every cycle checks the enables are never both high.
